// File: rtl/simple_uart_pkg.sv
// simple_uart_tx shared definitions
// register map, FSM states, STATUS layout
package simple_uart_pkg;

  localparam logic [7:0] RegTxData = 8'h00;
  localparam logic [7:0] RegStatus = 8'h01;
  localparam logic [7:0] RegCtrl   = 8'h02;
  localparam logic [7:0] RegClkDiv = 8'h03;

  localparam int StatusFull  = 0;
  localparam int StatusEmpty = 1;
  localparam int StatusBusy  = 2;
  localparam int StatusLvlLo = 8;
  localparam int StatusLvlHi = 14;

  localparam int CtrlTxEn  = 0;
  localparam int CtrlIrqEn = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_e;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } uart_rsp_t;

  // a zero divider would stall the baud counter
  function automatic logic [15:0] clkdiv_fix(
    input logic [15:0] v
  );
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/simple_uart_fifo.sv
// simple_uart_fifo: byte FIFO, fall-through read
// extra pointer bit separates full from empty
module simple_uart_fifo #(
  parameter int Depth = 8,
  localparam int PtrW = $clog2(Depth),
  localparam int LvlW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            full,
  output logic            empty,
  output logic [LvlW-1:0] level
);

  logic [7:0]    mem [Depth];
  logic [PtrW:0] wr_ptr_q;
  logic [PtrW:0] rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  =
    (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[PtrW-1:0]];

  // storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_q[PtrW-1:0]] <= wdata;
    end
  end

  // read and write pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/simple_uart_tx.sv
// simple_uart_tx: bus-mapped 8N1 transmitter
// register decode, response reg, TX FSM, irq
module simple_uart_tx
  import simple_uart_pkg::*;
#(
  parameter int          DataWidth    = 32,
  parameter int          AddressWidth = 32,
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd868
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int LvlW = $clog2(FifoDepth) + 1;

  logic [7:0]      reg_idx;
  logic            sel_txdata;
  logic            sel_status;
  logic            sel_ctrl;
  logic            sel_clkdiv;
  logic            wr_txdata;
  logic            wr_ctrl;
  logic            wr_clkdiv;

  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LvlW-1:0] fifo_level;

  logic            tx_en_q;
  logic            irq_en_q;
  logic [15:0]     clkdiv_q;
  logic [15:0]     clkdiv_new;

  uart_tx_state_e  state_q;
  logic [15:0]     baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            irq_q;
  logic            busy;
  logic            bit_end;
  logic [15:0]     baud_reload;

  logic [31:0]     status_word;
  logic [31:0]     rd_data;
  logic            rd_err;
  uart_rsp_t       rsp_q;

  logic            unused_bits;

  assign unused_bits = ^{addr_i[AddressWidth-1:10],
                         addr_i[1:0],
                         wdata_i[DataWidth-1:16],
                         be_i[3:2]};

  assign reg_idx    = addr_i[9:2];
  assign sel_txdata = req_i && (reg_idx == RegTxData);
  assign sel_status = req_i && (reg_idx == RegStatus);
  assign sel_ctrl   = req_i && (reg_idx == RegCtrl);
  assign sel_clkdiv = req_i && (reg_idx == RegClkDiv);

  assign wr_txdata = sel_txdata & we_i & be_i[0];
  assign wr_ctrl   = sel_ctrl & we_i & be_i[0];
  assign wr_clkdiv = sel_clkdiv & we_i & (|be_i[1:0]);

  assign fifo_push = wr_txdata & ~fifo_full;

  assign busy        = (state_q != TX_IDLE);
  assign bit_end     = (baud_cnt_q == 16'd0);
  assign baud_reload = clkdiv_q - 16'd1;

  // a frame may start from IDLE or chain straight out of STOP
  assign fifo_pop = tx_en_q & ~fifo_empty &
    ((state_q == TX_IDLE) |
     ((state_q == TX_STOP) & bit_end));

  simple_uart_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (wdata_i[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // STATUS image, sampled in the request cycle
  always_comb begin
    status_word = '0;
    status_word[StatusFull]  = fifo_full;
    status_word[StatusEmpty] = fifo_empty;
    status_word[StatusBusy]  = busy;
    status_word[StatusLvlHi:StatusLvlLo] =
      7'(fifo_level);
  end

  // merge byte lanes of a CLKDIV write
  always_comb begin
    clkdiv_new = clkdiv_q;
    if (be_i[0]) clkdiv_new[7:0]  = wdata_i[7:0];
    if (be_i[1]) clkdiv_new[15:8] = wdata_i[15:8];
  end

  // read mux and error decode
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      sel_txdata: rd_err = wr_txdata & fifo_full;
      sel_status: begin
        rd_err = we_i;
        if (!we_i) rd_data = status_word;
      end
      sel_ctrl: begin
        if (!we_i) rd_data = {30'b0, irq_en_q, tx_en_q};
      end
      sel_clkdiv: begin
        if (!we_i) rd_data = {16'b0, clkdiv_q};
      end
      default: rd_err = req_i;
    endcase
  end

  // CTRL and CLKDIV registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      clkdiv_q <= ClkDivReset;
    end else begin
      if (wr_ctrl) begin
        tx_en_q  <= wdata_i[CtrlTxEn];
        irq_en_q <= wdata_i[CtrlIrqEn];
      end
      if (wr_clkdiv) begin
        clkdiv_q <= clkdiv_fix(clkdiv_new);
      end
    end
  end

  // one registered response per request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q.rvalid <= req_i;
      rsp_q.err    <= rd_err;
      rsp_q.rdata  <= rd_data;
    end
  end

  // transmit FSM with registered line output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= TX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (fifo_pop) begin
            shift_q    <= fifo_rdata;
            baud_cnt_q <= baud_reload;
            tx_q       <= 1'b0;
            state_q    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud_cnt_q <= baud_reload;
            bit_idx_q  <= '0;
            tx_q       <= shift_q[0];
            state_q    <= TX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= baud_reload;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              shift_q    <= fifo_rdata;
              baud_cnt_q <= baud_reload;
              tx_q       <= 1'b0;
              state_q    <= TX_START;
            end else begin
              state_q <= TX_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  // drained interrupt, one cycle behind the condition
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & fifo_empty & ~busy;
    end
  end

  assign rvalid_o = rsp_q.rvalid;
  assign err_o    = rsp_q.err;
  assign rdata_o  = DataWidth'(rsp_q.rdata);
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: doc/simple_uart_tx.md
# simple_uart_tx

Memory-mapped transmit-only UART device for the simple system bus, attached as an additional device port next to RAM, SimCtrl and Timer. It accepts device-side requests from the bus, buffers bytes written by the core in a small FIFO, and serialises them 8N1 on `tx_o` at a programmable bit period. It raises a level interrupt when transmission has drained, for routing to `irq_fast_i`.

## Interface
- `DataWidth`, 32, bus data width; only 32 supported.
- `AddressWidth`, 32, bus address width.
- `FifoDepth`, 8, TX FIFO entries; power of two, 2..64.
- `ClkDivReset`, 16'd868, reset value of CLKDIV (cycles per bit).
- `clk_i` in 1: system clock, single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: device request from bus; always granted by the bus.
- `we_i` in 1: write enable.
- `be_i` in 4: byte enables.
- `addr_i` in AddressWidth: byte address; `addr_i[9:2]` decoded (1 kB window).
- `wdata_i` in DataWidth: write data.
- `rvalid_o` out 1: response valid, exactly one per request.
- `rdata_o` out DataWidth: read data; 0 for writes.
- `err_o` out 1: error response, valid with `rvalid_o`.
- `tx_o` out 1: serial output, idle high.
- `irq_o` out 1: level interrupt.

## Operation
- Registers at offset `addr_i[9:2]`:
  - 0x0 TXDATA (W): when `be_i[0]`, push `wdata_i[7:0]`. Reads return 0.
  - 0x4 STATUS (RO): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bits[14:8] FIFO level.
  - 0x8 CTRL (RW): bit0 `tx_en`, bit1 `irq_en`. Other bits read 0.
  - 0xC CLKDIV (RW): bits[15:0]. A written value of 0 is stored as 1.
  - Any other offset: `err_o=1`, no side effect.
  - Writes to STATUS: ignored, `err_o=1`.
- Push while full: byte dropped, `err_o=1`. Fullness is evaluated before any same-cycle pop.
- Byte enables on CTRL/CLKDIV: a byte lane updates only when its `be_i` bit is set.
- TX FSM states: IDLE, START, DATA, STOP. A 16-bit baud counter counts CLKDIV cycles per bit; a 3-bit counter tracks bit index.
- IDLE: if `tx_en` and FIFO not empty, pop into the shift register and go to START.
- START: `tx_o=0` for CLKDIV cycles, then go to DATA.
- DATA: 8 bits, LSB first, CLKDIV cycles each, then go to STOP.
- STOP: `tx_o=1` for CLKDIV cycles. At the end, if `tx_en` and FIFO not empty, pop and go directly to START (no idle bit); otherwise go to IDLE.
- Clearing `tx_en` mid-frame: the current frame completes; no further pops.
- CLKDIV written mid-frame: the new value loads at the next bit boundary.
- `irq_o` = registered `irq_en & empty & ~busy`.

## Timing
- Reset values: `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `tx_o=1`, `irq_o=0`. FIFO empty, FSM in IDLE, CTRL=0, CLKDIV=`ClkDivReset`.
- Response latency: `rvalid_o`, `rdata_o` and `err_o` are registered and assert the cycle after `req_i`. Back-to-back requests are supported every cycle.
- STATUS reads sample state at the request cycle.
- Start-bit latency: TXDATA write in cycle N with FIFO empty, FSM IDLE, `tx_en=1` → entry visible in cycle N+1 → popped in N+1 → `tx_o` falls in N+2.
- Frame duration: exactly 10×CLKDIV cycles. Back-to-back frames are contiguous.
- Reset asserted mid-frame: `tx_o` returns to 1 asynchronously and FIFO contents are lost.
- `irq_o` lags the condition by one cycle.

## Structure
- Package `simple_uart_pkg` holds:
  - register offset localparams;
  - the `uart_tx_state_e` enum (IDLE/START/DATA/STOP);
  - STATUS bit positions.
- Sub-module `simple_uart_fifo`: synchronous FIFO, parameter `Depth`.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Pointers are log2(Depth)+1 bits wide to disambiguate full from empty.
- Top level contains register decode, response register, FSM and counters.
- Add the block to the system as a fourth `bus_device_e` entry: base 0x40000, mask ~0x3FF.

## Test plan
- Reset, then read STATUS → `rdata_o`=0x0000_0002 one cycle after `req_i`; `tx_o`=1, `irq_o`=0.
- CLKDIV=4, CTRL=1, write TXDATA 0xA5 → `tx_o` falls 2 cycles after the write. Waveform 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40 cycles total.
- CTRL=0, write 9 bytes with `FifoDepth`=8 → first 8 return `err_o=0`, 9th returns `err_o=1`; STATUS level=8, full=1.
- Set CTRL=1 with 2 queued bytes and CLKDIV=2 → two contiguous frames (40 cycles, no idle gap), then busy=0.
- CTRL=3, queue 1 byte → `irq_o`=0 during the frame, rises one cycle after STOP ends; write CLKDIV=0 → reads back 1.
- Read offset 0x10 → `err_o`=1, `rdata_o`=0; assert `rst_ni` mid-DATA → `tx_o`=1 immediately, STATUS empty after reset.
